// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: shares the single main-memory port between the
// instruction-side and data-side cache controllers. One 128-bit line
// transaction is in flight at a time. Simultaneous requests are granted
// round-robin, and each transaction ends with a one-cycle done pulse to
// the side that owned it.
module main_mem_arbiter #(
  parameter int LINE_BITS = 128,
  parameter int ADDR_BITS = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  // instruction side
  input  logic                 i_req,
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic [LINE_BITS-1:0] i_rdata,
  output logic                 i_done,
  // data side
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 d_done,
  // main memory
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Set when the data side was granted most recently. It also selects
  // which side gets the done pulse in RESP, because the port being served
  // is always the one granted last.
  logic last_grant_d;
  logic grant_i;
  logic grant_d;

  // Round-robin grant: on a tie the side that was not granted last wins.
  always_comb begin
    // NOTE: every signal written here gets a default first, so that no path
    // leaves it unassigned and infers a latch.
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      grant_d = d_req && (!i_req || !last_grant_d);
      grant_i = i_req && !grant_d;
    end
  end

  // State register. Reset drops straight to IDLE, which abandons any
  // transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the clock edge.
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
      end
      BUSY_I:  if (mem_ack) state_nxt = RESP;
      BUSY_D:  if (mem_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state. mem_req falls as soon as reset is
  // asserted, because the reset acts on the state register asynchronously.
  always_comb begin
    mem_req = (state == BUSY_I) || (state == BUSY_D);
    i_done  = (state == RESP) && !last_grant_d;
    d_done  = (state == RESP) &&  last_grant_d;
  end

  // Register the request fields on a grant. They stay stable until the
  // next grant. An I grant leaves mem_wdata unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      last_grant_d <= 1'b0;
    end else if (grant_d) begin
      mem_addr     <= {d_addr[ADDR_BITS-1:4], 4'b0000};
      mem_we       <= d_we;
      mem_wdata    <= d_wdata;
      last_grant_d <= 1'b1;
    end else if (grant_i) begin
      mem_addr     <= {i_addr[ADDR_BITS-1:4], 4'b0000};
      mem_we       <= 1'b0;
      last_grant_d <= 1'b0;
    end
  end

  // Capture the returned line, but only for read completions of the
  // owning port. Writes and an mem_ack outside BUSY leave both lines alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else if (mem_ack) begin
      if (state == BUSY_I)                 i_rdata <= mem_rdata;
      else if (state == BUSY_D && !mem_we) d_rdata <= mem_rdata;
    end
  end

endmodule

// File: doc/main_mem_arbiter.md
# main_mem_arbiter

Arbiter between the processor's two cache controllers (instruction side, data side) and the single main-memory port. It serialises 128-bit line fills and line write-backs, grants with round-robin on conflicts, and returns read lines plus a one-cycle completion pulse to the requesting side. It sits directly downstream of the processor's instruction and data memory controllers and upstream of main memory.

## Interface
- LINE_BITS, 128: cache line width in bits (4 words).
- ADDR_BITS, 32: byte address width.

- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction-side line fill request; held high until i_done.
- i_addr  in  ADDR_BITS  instruction-side byte address; stable while i_req is high.
- i_rdata  out  LINE_BITS  returned instruction line.
- i_done  out  1  one-cycle completion pulse to the instruction side.
- d_req  in  1  data-side request; held high until d_done.
- d_we  in  1  data-side direction: 1 = line write-back, 0 = line fill.
- d_addr  in  ADDR_BITS  data-side byte address.
- d_wdata  in  LINE_BITS  data-side write-back line.
- d_rdata  out  LINE_BITS  returned data line.
- d_done  out  1  one-cycle completion pulse to the data side.
- mem_req  out  1  main-memory request; held high until mem_ack.
- mem_we  out  1  main-memory write enable.
- mem_addr  out  ADDR_BITS  line-aligned address (bits [3:0] forced to 0).
- mem_wdata  out  LINE_BITS  line to write.
- mem_rdata  in  LINE_BITS  line read; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle pulse: transaction complete.

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: sample i_req/d_req. Only one high: grant it. Both high: grant the port not granted last (last_grant register). Neither: stay.
- On grant: register mem_addr = {addr[ADDR_BITS-1:4], 4'b0}, mem_we (d_we for D, 0 for I), mem_wdata (d_wdata for D, don't-care held at previous value for I). Set mem_req=1. Update last_grant. Go to BUSY_I/BUSY_D.
- BUSY_x: hold mem_req, mem_addr, mem_we, mem_wdata stable. On mem_ack: drop mem_req. On reads, capture mem_rdata into i_rdata or d_rdata. Go to RESP.
- RESP: pulse i_done or d_done (exactly one) for one cycle. Go to IDLE.
- i_rdata/d_rdata change only on read completions of their own port. They hold the last value otherwise. A D write does not modify d_rdata.
- mem_ack outside BUSY_x: ignored.
- Requester dropping req while BUSY_x (protocol violation): transaction still completes and done still pulses.

## Timing
- Reset (reset=0, async): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_rdata=0, d_rdata=0, i_done=0, d_done=0. last_grant=I, so the first tie goes to D.
- Reset mid-transaction: mem_req falls immediately and no done pulse is issued. Main memory must tolerate the abandoned request.
- req high in IDLE at cycle 0 -> mem_req high in cycle 1.
- mem_ack in cycle k (k>=1) -> mem_req low in cycle k+1 and done high in cycle k+1 only.
- Minimum req-to-done: 2 cycles (mem_ack in cycle 1, done in cycle 2).
- Requesters register on done and have req low in the cycle after done. The arbiter is back in IDLE that same cycle, so a stale req is never re-granted.
- Back-to-back operation:
  - The other port, if pending, is granted in the IDLE cycle after RESP, giving mem_req at RESP+2.
  - Throughput is one transaction per (memory latency + 3) cycles.
- Starvation bound: with both ports continuously requesting, grants strictly alternate D, I, D, I...

## Test plan
- Reset then i_req=1, i_addr=0x0000_1234; mem_ack at cycle 3 with mem_rdata=0xA5A5..A5 -> mem_req high in cycles 1-3, mem_addr=0x0000_1230, mem_we=0; i_done in cycle 4 only; i_rdata=0xA5A5..A5.
- d_req=1, d_we=1, d_addr=0x8000_004C, d_wdata=0x1111..11; mem_ack at cycle 1 -> mem_addr=0x8000_0040, mem_we=1, mem_wdata=0x1111..11; d_done in cycle 2; d_rdata unchanged.
- i_req and d_req rise in the same cycle after reset, both held continuously -> grant order D, I, D, I. No port gets two consecutive grants while the other is pending.
- D read in flight, then i_req rises mid-transaction -> I is granted only after D's RESP; i_rdata untouched by the D completion.
- reset pulsed low during BUSY_D, with mem_ack arriving later -> mem_req=0 immediately, no d_done, the late mem_ack is ignored, and the next request is serviced normally.
- Spurious mem_ack in IDLE -> no state change, no done pulse, rdata registers unchanged.
